// File: rtl/circle_motion_ctrl.sv
// Frame-synchronous circle sprite position controller: samples direction buttons once per
// vertical blank, rate-limits with a frame divider, clamps the center on screen.
// Optional build macro MOTION_ACCEL_EN enables a hold-to-accelerate step of 4.
module circle_motion_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned RADIUS    = 25,
    parameter int unsigned INIT_X    = 100,
    parameter int unsigned INIT_Y    = 100,
    parameter int unsigned FRAME_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic [9:0] i_coord_x,
    input  logic [9:0] i_coord_y,
    output logic [9:0] o_center_x,
    output logic [9:0] o_center_y,
    output logic       o_frame_tick,
    output logic       o_moving
);

    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic signed [10:0] X_MIN = 11'(RADIUS);
    localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic signed [10:0] Y_MIN = 11'(RADIUS);
    localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - 1 - RADIUS);

    typedef enum logic [1:0] {StWaitActive, StWaitBlank, StSample, StUpdate} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [9:0]         r_center_x;
    logic [9:0]         r_center_y;
    logic               r_moving;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_fire;
    logic [3:0]         r_dir;       // {up, down, left, right}
    logic               w_blank;
    logic signed [10:0] w_step;
    logic signed [10:0] w_cx;
    logic signed [10:0] w_cy;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic [9:0]         w_new_x;
    logic [9:0]         w_new_y;
    logic               w_unused_coord_x;

    assign w_unused_coord_x = ^i_coord_x;
    assign w_blank          = (i_coord_y >= 10'(V_ACTIVE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StWaitActive: if (!w_blank) w_state_next = StWaitBlank;
            StWaitBlank:  if (w_blank) w_state_next = StSample;
            StSample:     w_state_next = StUpdate;
            StUpdate:     w_state_next = StWaitActive;
            default:      w_state_next = StWaitActive;
        endcase
    end

`ifdef MOTION_ACCEL_EN
    logic [3:0] r_hold_cnt;
    logic [3:0] r_last_dir;
    logic [3:0] w_hold_next;

    // The step is chosen from the count this update produces, so the 9th held update is fast.
    always_comb begin
        w_hold_next = 4'd0;
        if ((r_dir != 4'd0) && (r_dir == r_last_dir)) begin
            w_hold_next = (r_hold_cnt == 4'hF) ? r_hold_cnt : r_hold_cnt + 4'd1;
        end
        w_step = (w_hold_next >= 4'd8) ? 11'sd4 : 11'sd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_hold_cnt <= 4'd0;
            r_last_dir <= 4'd0;
        end else if ((r_state == StUpdate) && r_fire) begin
            r_hold_cnt <= w_hold_next;
            r_last_dir <= r_dir;
        end
    end
`else
    assign w_step = 11'sd1;
`endif

    always_comb begin
        w_cx = $signed({1'b0, r_center_x});
        w_cy = $signed({1'b0, r_center_y});
        w_nx = w_cx;
        w_ny = w_cy;
        if (r_dir[0] && !r_dir[1]) w_nx = w_cx + w_step;
        else if (r_dir[1] && !r_dir[0]) w_nx = w_cx - w_step;
        if (r_dir[2] && !r_dir[3]) w_ny = w_cy + w_step;
        else if (r_dir[3] && !r_dir[2]) w_ny = w_cy - w_step;
        if (w_nx < X_MIN) w_nx = X_MIN;
        else if (w_nx > X_MAX) w_nx = X_MAX;
        if (w_ny < Y_MIN) w_ny = Y_MIN;
        else if (w_ny > Y_MAX) w_ny = Y_MAX;
        w_new_x = r_fire ? w_nx[9:0] : r_center_x;
        w_new_y = r_fire ? w_ny[9:0] : r_center_y;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= StWaitActive;
            r_center_x  <= 10'(INIT_X);
            r_center_y  <= 10'(INIT_Y);
            r_moving    <= 1'b0;
            r_frame_cnt <= '0;
            r_fire      <= 1'b0;
            r_dir       <= 4'd0;
        end else begin
            r_state <= w_state_next;
            // Buttons are captured on the edge that enters SAMPLE.
            if ((r_state == StWaitBlank) && w_blank) begin
                r_dir <= {i_up, i_down, i_left, i_right};
            end
            if (r_state == StSample) begin
                r_fire      <= (r_frame_cnt == CNT_LAST);
                r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
            end
            if (r_state == StUpdate) begin
                r_center_x <= w_new_x;
                r_center_y <= w_new_y;
                r_moving   <= (w_new_x != r_center_x) || (w_new_y != r_center_y);
            end
        end
    end

    assign o_center_x   = r_center_x;
    assign o_center_y   = r_center_y;
    assign o_moving     = r_moving;
    assign o_frame_tick = (r_state == StSample);

endmodule

// File: tb/tb_circle_motion_ctrl.sv
// Directed bench for circle_motion_ctrl: frame-level vector table plus clamp, accel and
// reset-during-update sequences.
module tb_circle_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right;
    logic [9:0] coord_x, coord_y;
    logic [9:0] center_x, center_y;
    logic       frame_tick, moving;

    int n_checks = 0;
    int n_errors = 0;
    int ticks;

    typedef struct {
        logic [3:0] act_btn;   // {up, down, left, right} during active video
        logic [3:0] blk_btn;   // buttons during blanking
        int         exp_x;
        int         exp_y;
        int         exp_mv;
    } vec_t;

    vec_t vecs[14];

    circle_motion_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_up        (up),
        .i_down      (down),
        .i_left      (left),
        .i_right     (right),
        .i_coord_x   (coord_x),
        .i_coord_y   (coord_y),
        .o_center_x  (center_x),
        .o_center_y  (center_y),
        .o_frame_tick(frame_tick),
        .o_moving    (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up, down, left, right} = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 4 active rows ending at 479, then 6 blank rows starting at 480.
    task automatic run_frame(input logic [3:0] act_btn, input logic [3:0] blk_btn);
        ticks = 0;
        set_btn(act_btn);
        for (int r = 0; r < 4; r++) begin
            coord_y = 10'(476 + r);
            coord_x = 10'(r * 37);
            step();
            ticks += int'(frame_tick);
        end
        set_btn(blk_btn);
        for (int r = 0; r < 6; r++) begin
            coord_y = 10'(480 + r);
            step();
            ticks += int'(frame_tick);
        end
    endtask

    task automatic run_pair(input logic [3:0] b);
        run_frame(b, b);
        run_frame(b, b);
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 100, 100, 0};
        vecs[1]  = '{4'b0000, 4'b0000, 100, 100, 0};
        vecs[2]  = '{4'b0001, 4'b0001, 100, 100, 0};
        vecs[3]  = '{4'b0001, 4'b0001, 101, 100, 1};
        vecs[4]  = '{4'b0001, 4'b0001, 101, 100, 0};
        vecs[5]  = '{4'b0001, 4'b0001, 102, 100, 1};
        vecs[6]  = '{4'b1110, 4'b1110, 102, 100, 0};
        vecs[7]  = '{4'b1110, 4'b1110, 101, 100, 1};
        vecs[8]  = '{4'b1110, 4'b1110, 101, 100, 0};
        vecs[9]  = '{4'b1110, 4'b1110, 100, 100, 1};
        vecs[10] = '{4'b0101, 4'b0101, 100, 100, 0};
        vecs[11] = '{4'b0101, 4'b0101, 101, 101, 1};
        vecs[12] = '{4'b0001, 4'b0000, 101, 101, 0};
        vecs[13] = '{4'b0001, 4'b0000, 101, 101, 0};

        reset   = 1'b0;
        set_btn(4'b0000);
        coord_x = 10'd0;
        coord_y = 10'd500;
        repeat (3) step();
        check("reset_x", int'(center_x), 100);
        check("reset_y", int'(center_y), 100);
        check("reset_moving", int'(moving), 0);
        check("reset_tick", int'(frame_tick), 0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_frame(vecs[i].act_btn, vecs[i].blk_btn);
            check($sformatf("vec%0d_x", i), int'(center_x), vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), int'(center_y), vecs[i].exp_y);
            check($sformatf("vec%0d_moving", i), int'(moving), vecs[i].exp_mv);
            check($sformatf("vec%0d_ticks", i), ticks, 1);
        end

`ifdef MOTION_ACCEL_EN
        // 8 updates at step 1 then 2 at step 4 from y=101.
        for (int i = 0; i < 10; i++) run_pair(4'b0100);
        check("accel_y", int'(center_y), 117);
        check("accel_x", int'(center_x), 101);
`else
        for (int i = 0; i < 75; i++) run_pair(4'b0010);
        check("left_to_26_x", int'(center_x), 26);
        check("left_to_26_y", int'(center_y), 101);
        for (int k = 0; k < 3; k++) begin
            run_pair(4'b0010);
            check($sformatf("clamp_left%0d_x", k), int'(center_x), 25);
            check($sformatf("clamp_left%0d_moving", k), int'(moving), (k == 0) ? 1 : 0);
        end
        for (int i = 0; i < 353; i++) run_pair(4'b0100);
        check("down_to_454_y", int'(center_y), 454);
        check("down_to_454_moving", int'(moving), 1);
        run_pair(4'b0100);
        check("clamp_down_y", int'(center_y), 454);
        check("clamp_down_moving", int'(moving), 0);
        check("clamp_down_x", int'(center_x), 25);
`endif

        // Reset asserted in UPDATE of a fired frame must discard the pending move.
        reset = 1'b0;
        step();
        reset = 1'b1;
        run_frame(4'b0001, 4'b0001);
        check("post_reset_f1_x", int'(center_x), 100);
        set_btn(4'b0001);
        for (int r = 0; r < 4; r++) begin
            coord_y = 10'(300 + r);
            step();
        end
        coord_y = 10'd490;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                seen = frame_tick;
            end
            check("update_abort_tick_seen", int'(seen), 1);
            step();
            reset = 1'b0;
            step();
            reset = 1'b1;
            check("update_abort_x", int'(center_x), 100);
            check("update_abort_y", int'(center_y), 100);
            check("update_abort_moving", int'(moving), 0);
        end
        run_frame(4'b0001, 4'b0001);
        run_frame(4'b0001, 4'b0001);
        check("after_abort_x", int'(center_x), 101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/circle_motion_ctrl.md
# circle_motion_ctrl

Frame-synchronous position controller for the circle sprite. Samples the four direction buttons once per video frame during vertical blanking, rate-limits motion with a frame divider, clamps the circle center so the whole circle stays on screen, and drives the `center_x`/`center_y` values consumed by the pixel renderer. Position never changes while active video is being scanned, so the rendered circle cannot tear.

## Interface
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows; `coord_y >= V_ACTIVE` means vertical blanking.
- `RADIUS`, 25: circle radius used for clamping.
- `INIT_X`, 100: reset value of `center_x`.
- `INIT_Y`, 100: reset value of `center_y`.
- `FRAME_DIV`, 2: number of frames per motion update, ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `up`, `down`, `left`, `right`  in  1 each  level direction requests; synchronous to `clk`.
- `coord_x`  in  10  current scan column from the sync generator.
- `coord_y`  in  10  current scan row from the sync generator.
- `center_x`  out  10  circle center column, registered.
- `center_y`  out  10  circle center row, registered.
- `frame_tick`  out  1  one-cycle pulse per frame, asserted in the SAMPLE state.
- `moving`  out  1  registered; high if the last UPDATE changed either coordinate.

## Operation
- The FSM has four states. WAIT_ACTIVE is entered on reset:
  - WAIT_ACTIVE: go to WAIT_BLANK when `coord_y < V_ACTIVE`.
  - WAIT_BLANK: go to SAMPLE when `coord_y >= V_ACTIVE`.
  - SAMPLE: one cycle. Assert `frame_tick`, latch `up/down/left/right` into `dir_q`, and evaluate the divider. Always go to UPDATE.
  - UPDATE: one cycle. Apply motion only if the divider fired, then go to WAIT_ACTIVE.
- The WAIT_ACTIVE gate ensures exactly one SAMPLE per blanking interval, however long blanking lasts in `clk` cycles.
- Frame divider:
  - `frame_cnt` counts 0..FRAME_DIV-1 and advances in SAMPLE.
  - It fires when `frame_cnt == FRAME_DIV-1`, then wraps to 0.
  - With FRAME_DIV=1 it fires every frame.
- Direction resolution:
  - `dy = down - up`; `dx = right - left`. Opposing buttons cancel to 0 on that axis.
  - The two axes are independent, so diagonal moves are allowed.
- Arithmetic:
  - Compute in 11-bit signed, `next = center + dx*step`.
  - Clamp `center_x` to [RADIUS, H_ACTIVE-1-RADIUS] = [25, 614].
  - Clamp `center_y` to [RADIUS, V_ACTIVE-1-RADIUS] = [25, 454].
  - Wrap-around is never permitted.
  - `step` = 1 unless configured otherwise (see Configuration).
- `moving` is updated in every UPDATE cycle: 1 if the new center differs from the old one, else 0. It holds its value otherwise. At a clamp boundary, `moving` = 0.
- Reset values: `center_x = INIT_X`, `center_y = INIT_Y`, `frame_tick = 0`, `moving = 0`, `frame_cnt = 0`, `dir_q = 0`, state = WAIT_ACTIVE.
- Reset asserted in any state aborts the sequence at the next edge. No partial update is committed.

## Timing
- Cycle 0 is the first cycle with `coord_y >= V_ACTIVE` while in WAIT_BLANK.
- Cycle 1: SAMPLE. `frame_tick` = 1 and buttons are latched; buttons sampled at the cycle-0→1 edge are used.
- Cycle 2: UPDATE.
- New `center_x`/`center_y` and `moving` are visible from cycle 3, a latency of 3 clocks from blank entry.
- Buttons are ignored outside SAMPLE. A press shorter than the blanking window that misses SAMPLE is dropped.
- Outputs are stable throughout active video.

## Configuration
- `MOTION_ACCEL_EN`:
  - Defined: adds a 4-bit saturating `hold_cnt`.
    - It increments on each fired update where `dir_q` is nonzero and equals the previous fired update's `dir_q`.
    - It clears to 0 on any fired update with a different or zero direction, and on reset.
    - `step` = 1 while `hold_cnt < 8`, and `step` = 4 once `hold_cnt >= 8`.
  - Undefined: no `hold_cnt`, and `step` is constant 1.
  - Clamping rules are identical in both builds.

## Test plan
- Reset, then scan one frame with no buttons → `center` = (100,100), `moving` = 0, `frame_tick` = 1 exactly once per frame.
- FRAME_DIV=2, hold `right` for 4 frames → `center_x` goes 100→101→102 (changes on frames 2 and 4 only), `center_y` = 100.
- Hold `up` and `down` together plus `left` for 2 fired updates → `center_y` = 100, `center_x` = 98.
- Start at (26,100) and hold `left` for 3 fired updates → 25, 25, 25; `moving` = 0 on the second and third updates.
- Toggle `right` during active video only (low in blanking) → no motion; assert `reset` low during UPDATE → center = (100,100) next cycle.
- With `MOTION_ACCEL_EN` defined, hold `down` for 10 fired updates → `center_y` = 100+8×1+2×4 = 116.
